// File: rtl/cordic_pkg.sv
// Shared constants, types and helpers for the CORDIC request scheduler.
// Angles use 2^32 = 360 degrees in two's complement.
package cordic_pkg;

  localparam int DATA_W    = 16;
  localparam int ANG_W     = 32;
  localparam int TAG_MAX_W = 3;

  localparam logic [ANG_W-1:0] ANG_90  = 32'h4000_0000;
  localparam logic [ANG_W-1:0] ANG_180 = 32'h8000_0000;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic                 fold;
  } dl_ent_t;

  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Two's complement negate that maps the most negative value to the most positive one.
  function automatic logic [DATA_W-1:0] sat_neg(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    if (v == {1'b1, {(DATA_W-1){1'b0}}}) begin
      r = {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      r = (~v) + {{(DATA_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/cordic_req_sched_rr_arbiter.sv
// Round-robin arbiter: the first requester at or after the pointer wins;
// the pointer moves past the winner only when the grant is taken.
module rr_arbiter
  import cordic_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int TW = tag_width(N);

  logic [TW-1:0] rr_q;
  logic [TW-1:0] rr_d;
  logic [TW-1:0] win_s;
  logic          found_s;
  int            idx_s;

  // Scan from the pointer, wrapping, and grant the first active request.
  always_comb begin
    grant   = '0;
    win_s   = rr_q;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < N; k++) begin
      idx_s = (int'(rr_q) + k) % N;
      if (!found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        win_s        = TW'(idx_s);
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next pointer: one past the winner on a taken grant, otherwise unchanged.
  always_comb begin
    if (advance) begin
      rr_d = (win_s == TW'(N - 1)) ? '0 : win_s + TW'(1);
    end else begin
      rr_d = rr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/cordic_req_sched.sv
// Shares one fixed-latency CORDIC among N requesters; tags and fold flags ride a
// delay line matched to the CORDIC so each result returns to its issuer, un-folded.
module cordic_req_sched
  import cordic_pkg::*;
#(
  parameter int N          = 4,
  parameter int CORDIC_LAT = 16,
  parameter int FOLD       = 1,
  localparam int IFW       = $clog2(CORDIC_LAT + 3)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [N-1:0]        req_valid,
  output logic [N-1:0]        req_ready,
  input  logic [16*N-1:0]     req_x,
  input  logic [16*N-1:0]     req_y,
  input  logic [32*N-1:0]     req_z,
  output logic [15:0]         c_xin,
  output logic [15:0]         c_yin,
  output logic [31:0]         c_zangle,
  input  logic [15:0]         c_xout,
  input  logic [15:0]         c_yout,
  output logic [N-1:0]        rsp_valid,
  output logic [15:0]         rsp_x,
  output logic [15:0]         rsp_y,
  output logic [IFW-1:0]      inflight,
  output logic                busy
);

  localparam int TAG_W = tag_width(N);

  logic              hs_s;
  logic [TAG_W-1:0]  g_s;
  logic [DATA_W-1:0] sel_x_s, sel_y_s;
  logic [ANG_W-1:0]  sel_z_s, z_plus90_s;
  logic              fold_s;

  logic [DATA_W-1:0] c_xin_q, c_xin_d, c_yin_q, c_yin_d;
  logic [ANG_W-1:0]  c_zangle_q, c_zangle_d;
  dl_ent_t           iss_q, iss_d;
  dl_ent_t           dl_q [CORDIC_LAT];
  dl_ent_t           dl_d [CORDIC_LAT];
  dl_ent_t           dl_out_s;
  logic [N-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_x_q, rsp_x_d, rsp_y_q, rsp_y_d;
  logic [IFW-1:0]    inflight_q, inflight_d;
  logic              busy_q, busy_d;

  rr_arbiter #(.N(N)) u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req_valid),
    .advance (hs_s),
    .grant   (req_ready)
  );

  // Select the winner's operands and fold angles in [90, 270) by subtracting 180.
  always_comb begin
    hs_s = |(req_valid & req_ready);
    g_s  = '0;
    for (int k = 0; k < N; k++) begin
      g_s = g_s | (req_ready[k] ? TAG_W'(k) : TAG_W'(0));
    end
    sel_x_s    = req_x[DATA_W*g_s +: DATA_W];
    sel_y_s    = req_y[DATA_W*g_s +: DATA_W];
    sel_z_s    = req_z[ANG_W*g_s +: ANG_W];
    // Adding 90 degrees puts exactly the [90, 270) range into the upper half.
    z_plus90_s = sel_z_s + ANG_90;
    fold_s     = (FOLD != 0) && z_plus90_s[ANG_W-1];
    if (hs_s) begin
      c_xin_d    = sel_x_s;
      c_yin_d    = sel_y_s;
      c_zangle_d = fold_s ? (sel_z_s ^ ANG_180) : sel_z_s;
      iss_d      = '{valid: 1'b1, tag: TAG_MAX_W'(g_s), fold: fold_s};
    end else begin
      c_xin_d    = c_xin_q;
      c_yin_d    = c_yin_q;
      c_zangle_d = c_zangle_q;
      iss_d      = '0;
    end
  end

  // Tag/fold delay line; its last stage lines up with c_xout/c_yout.
  always_comb begin
    dl_d[0] = iss_q;
    for (int k = 1; k < CORDIC_LAT; k++) begin
      dl_d[k] = dl_q[k-1];
    end
    dl_out_s = dl_q[CORDIC_LAT-1];
  end

  // Result capture, un-folding and in-flight accounting.
  always_comb begin
    if (dl_out_s.valid) begin
      rsp_valid_d = N'(1'b1) << dl_out_s.tag;
      if (dl_out_s.fold) begin
        rsp_x_d = sat_neg(c_xout);
        rsp_y_d = sat_neg(c_yout);
      end else begin
        rsp_x_d = c_xout;
        rsp_y_d = c_yout;
      end
    end else begin
      rsp_valid_d = '0;
      rsp_x_d     = rsp_x_q;
      rsp_y_d     = rsp_y_q;
    end
    inflight_d = inflight_q + IFW'(hs_s) - IFW'(|rsp_valid_q);
    busy_d     = (inflight_d != '0);
  end

  // All state registers; reset discards everything in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      c_xin_q     <= '0;
      c_yin_q     <= '0;
      c_zangle_q  <= '0;
      iss_q       <= '0;
      for (int k = 0; k < CORDIC_LAT; k++) begin
        dl_q[k] <= '0;
      end
      rsp_valid_q <= '0;
      rsp_x_q     <= '0;
      rsp_y_q     <= '0;
      inflight_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      c_xin_q     <= c_xin_d;
      c_yin_q     <= c_yin_d;
      c_zangle_q  <= c_zangle_d;
      iss_q       <= iss_d;
      for (int k = 0; k < CORDIC_LAT; k++) begin
        dl_q[k] <= dl_d[k];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_x_q     <= rsp_x_d;
      rsp_y_q     <= rsp_y_d;
      inflight_q  <= inflight_d;
      busy_q      <= busy_d;
    end
  end

  assign c_xin     = c_xin_q;
  assign c_yin     = c_yin_q;
  assign c_zangle  = c_zangle_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_x     = rsp_x_q;
  assign rsp_y     = rsp_y_q;
  assign inflight  = inflight_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cordic_req_sched.sv
// Directed bench for cordic_req_sched: a FOLD=1 and a FOLD=0 instance share the
// request inputs, each driving its own behavioural CORDIC model (gain included).
module tb_cordic_req_sched;
  import cordic_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 16;
  localparam real K  = 1.6467602;
  localparam real PI = 3.14159265358979;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [16*N-1:0] req_x, req_y;
  logic [32*N-1:0] req_z;

  logic [N-1:0] rdy_a, rdy_b, rv_a, rv_b;
  logic [15:0]  cx_a, cy_a, cx_b, cy_b, ox_a, oy_a, ox_b, oy_b, rx_a, ry_a, rx_b, ry_b;
  logic [31:0]  cz_a, cz_b;
  logic [4:0]   inf_a, inf_b;
  logic         busy_a, busy_b;
  logic [31:0]  pipe_a [LAT];
  logic [31:0]  pipe_b [LAT];

  logic         sel = 1'b0;
  logic [N-1:0] o_rdy, o_rv;
  logic [15:0]  o_cx, o_rx, o_ry;
  logic [31:0]  o_cz;
  logic [4:0]   o_inf;
  logic         o_busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  cordic_req_sched #(.N(N), .CORDIC_LAT(LAT), .FOLD(1)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy_a),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .c_xin(cx_a), .c_yin(cy_a), .c_zangle(cz_a), .c_xout(ox_a), .c_yout(oy_a),
    .rsp_valid(rv_a), .rsp_x(rx_a), .rsp_y(ry_a), .inflight(inf_a), .busy(busy_a));

  cordic_req_sched #(.N(N), .CORDIC_LAT(LAT), .FOLD(0)) dut_nofold (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy_b),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .c_xin(cx_b), .c_yin(cy_b), .c_zangle(cz_b), .c_xout(ox_b), .c_yout(oy_b),
    .rsp_valid(rv_b), .rsp_x(rx_b), .rsp_y(ry_b), .inflight(inf_b), .busy(busy_b));

  assign o_rdy  = sel ? rdy_b  : rdy_a;
  assign o_rv   = sel ? rv_b   : rv_a;
  assign o_cx   = sel ? cx_b   : cx_a;
  assign o_cz   = sel ? cz_b   : cz_a;
  assign o_rx   = sel ? rx_b   : rx_a;
  assign o_ry   = sel ? ry_b   : ry_a;
  assign o_inf  = sel ? inf_b  : inf_a;
  assign o_busy = sel ? busy_b : busy_a;

  function automatic logic [15:0] sat16(input real r);
    real q;
    q = (r >= 0.0) ? r + 0.5 : r - 0.5;
    if (q > 32767.0) return 16'h7FFF;
    else if (q < -32768.0) return 16'h8000;
    else return 16'($rtoi(q));
  endfunction

  function automatic logic [31:0] cordic_f(input logic [15:0] x, input logic [15:0] y,
                                           input logic [31:0] z);
    real a, xr, yr;
    a  = real'($signed(z)) * PI / 2147483648.0;
    xr = real'($signed(x));
    yr = real'($signed(y));
    return {sat16(K * (xr * $cos(a) - yr * $sin(a))), sat16(K * (yr * $cos(a) + xr * $sin(a)))};
  endfunction

  // Ideal rotator: inputs captured one edge after issue, result LAT edges after issue.
  always @(posedge clock) begin
    pipe_a[0] <= cordic_f(cx_a, cy_a, cz_a);
    pipe_b[0] <= cordic_f(cx_b, cy_b, cz_b);
    for (int k = 1; k < LAT; k++) begin
      pipe_a[k] <= pipe_a[k-1];
      pipe_b[k] <= pipe_b[k-1];
    end
  end
  assign ox_a = pipe_a[LAT-1][31:16];
  assign oy_a = pipe_a[LAT-1][15:0];
  assign ox_b = pipe_b[LAT-1][31:16];
  assign oy_b = pipe_b[LAT-1][15:0];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_tol(input string name, input int act, input int exp);
    n_chk++;
    if (act > exp + 2 || act < exp - 2) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +/-2", name, act, exp);
    end
  endtask

  typedef struct {
    bit          inst;
    int          r;
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] z;
    logic [31:0] exp_z;
    int          exp_x;
    int          exp_y;
  } vec_t;

  // Starts and ends on a falling edge with no request pending.
  task automatic run_one(input vec_t v, input string nm);
    int lat;
    sel = v.inst;
    req_valid = '0;
    req_valid[v.r] = 1'b1;
    req_x[16*v.r +: 16] = v.x;
    req_y[16*v.r +: 16] = v.y;
    req_z[32*v.r +: 32] = v.z;
    #1;
    chk($sformatf("%s ready", nm), o_rdy, 1 << v.r);
    @(posedge clock);
    #1 req_valid = '0;
    @(negedge clock);
    chk($sformatf("%s zangle", nm), o_cz, v.exp_z);
    chk($sformatf("%s xin", nm), o_cx, v.x);
    chk($sformatf("%s inflight1", nm), o_inf, 1);
    lat = 0;
    while (o_rv == '0 && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    // Strobe appears after the (LAT+1)th edge past the handshake edge.
    chk($sformatf("%s latency", nm), lat, LAT + 1);
    chk($sformatf("%s rsp_valid", nm), o_rv, 1 << v.r);
    chk_tol($sformatf("%s rsp_x", nm), int'($signed(o_rx)), v.exp_x);
    chk_tol($sformatf("%s rsp_y", nm), int'($signed(o_ry)), v.exp_y);
    @(negedge clock);
    chk($sformatf("%s strobe_len", nm), o_rv, 0);
    chk($sformatf("%s inflight0", nm), o_inf, 0);
    chk($sformatf("%s busy0", nm), o_busy, 0);
  endtask

  task automatic drive_burst(input int cycles, input bit check_rr);
    req_valid = 4'hF;
    for (int i = 0; i < N; i++) begin
      req_x[16*i +: 16] = 16'(100 * (i + 1));
      req_y[16*i +: 16] = 16'h0000;
      req_z[32*i +: 32] = 32'h0000_0000;
    end
    for (int k = 0; k < cycles; k++) begin
      #1;
      if (check_rr) chk($sformatf("burst grant %0d", k), rdy_a, 1 << (k % N));
      @(negedge clock);
    end
    req_valid = '0;
  endtask

  vec_t vecs [10];
  int   burst_x [N];
  int   wait_n;
  int   stray;

  initial begin
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    req_z = '0;
    repeat (3) @(negedge clock);
    chk("reset c_xin", cx_a, 0);
    chk("reset c_zangle", cz_a, 0);
    chk("reset rsp_valid", rv_a, 0);
    chk("reset inflight", inf_a, 0);
    chk("reset busy", busy_a, 0);
    req_valid = 4'b0100;
    #1 chk("reset ready comb", rdy_a, 4'b0100);
    req_valid = '0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    vecs[0] = '{1'b0, 0, 16'd1944, 16'd0,    32'h0000_0000, 32'h0000_0000,  3201,     0};
    vecs[1] = '{1'b0, 2, 16'd1944, 16'd0,    32'h2000_0000, 32'h2000_0000,  2263,  2263};
    vecs[2] = '{1'b0, 1, 16'd1944, 16'd0,    32'h5555_5555, 32'hD555_5555, -1600,  2772};
    vecs[3] = '{1'b0, 3, 16'd1944, 16'd0,    32'hAAAA_AAAB, 32'h2AAA_AAAB, -1600, -2772};
    vecs[4] = '{1'b0, 0, 16'hB1E0, 16'd0,    32'h8000_0000, 32'h0000_0000, 32767,     0};
    vecs[5] = '{1'b0, 1, 16'd1944, 16'd0,    32'h3FFF_FFFF, 32'h3FFF_FFFF,     0,  3201};
    vecs[6] = '{1'b0, 2, 16'd1944, 16'd0,    32'hC000_0000, 32'hC000_0000,     0, -3201};
    vecs[7] = '{1'b0, 3, 16'd0,    16'd1000, 32'h0000_0000, 32'h0000_0000,     0,  1647};
    vecs[8] = '{1'b1, 0, 16'd1944, 16'd0,    32'h4000_0000, 32'h4000_0000,     0,  3201};
    vecs[9] = '{1'b1, 3, 16'd1944, 16'd0,    32'h8000_0000, 32'h8000_0000, -3201,     0};
    foreach (vecs[i]) run_one(vecs[i], $sformatf("vec%0d", i));

    // Round-robin burst from a fresh pointer: 12 grants, 12 back-to-back results.
    sel = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    burst_x = '{165, 329, 494, 659};
    drive_burst(12, 1'b1);
    chk("burst inflight peak", inf_a, 12);
    wait_n = 0;
    while (rv_a == '0 && wait_n < 40) begin
      @(negedge clock);
      wait_n++;
    end
    chk("burst first rsp wait", wait_n, 6);
    for (int j = 0; j < 12; j++) begin
      chk($sformatf("burst rsp_valid %0d", j), rv_a, 1 << (j % N));
      chk_tol($sformatf("burst rsp_x %0d", j), int'($signed(rx_a)), burst_x[j % N]);
      @(negedge clock);
    end
    chk("burst inflight end", inf_a, 0);

    // Reset with ten requests outstanding.
    drive_burst(10, 1'b0);
    chk("pre-reset inflight", inf_a, 10);
    reset_n = 1'b0;
    #1;
    chk("mid reset c_xin", cx_a, 0);
    chk("mid reset c_yin", cy_a, 0);
    chk("mid reset c_zangle", cz_a, 0);
    chk("mid reset rsp_valid", rv_a, 0);
    chk("mid reset rsp_x", rx_a, 0);
    chk("mid reset rsp_y", ry_a, 0);
    chk("mid reset inflight", inf_a, 0);
    chk("mid reset busy", busy_a, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (rv_a != '0) stray++;
    end
    chk("post-reset stray responses", stray, 0);
    run_one('{1'b0, 1, 16'd1944, 16'd0, 32'h0000_0000, 32'h0000_0000, 3201, 0}, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected test to complete");
    $fatal(1);
  end

endmodule
